frame_swap_ctrl: RTL and testbench
==================================

FRAME_SWAP_CTRL -- requirements
Module: frame_swap_ctrl

Interface
REQ-001 Parameter CNT_W, default 8, width of swap_count and drop_count.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 n_rst  input  1  asynchronous, active-low reset.
REQ-004 enable  input  1  swap scheduling enable; when 0, no swap is issued.
REQ-005 frame_done  input  1  one-cycle pulse from the renderer: back buffer complete.
REQ-006 vblank  input  1  display vertical-blank level, synchronous to clk.
REQ-007 frameswap  output  1  one-cycle pulse commanding a buffer swap.
REQ-008 draw_sel  output  1  buffer index the renderer writes.
REQ-009 disp_sel  output  1  buffer index the display reads; always equals ~draw_sel.
REQ-010 draw_stall  output  1  renderer must not start a new frame while 1.
REQ-011 swap_count  output  CNT_W  number of swaps issued, wraps modulo 2^CNT_W.
REQ-012 drop_count  output  CNT_W  number of vblanks that repeated a frame, saturates at all-ones.
REQ-013 proto_err  output  1  sticky flag: frame_done received while draw_stall was 1.

Function
REQ-014 The block SHALL implement three states: DRAWING, PENDING and SWAP.
REQ-015 The block SHALL register vblank once and define vb_rise = vblank & ~vblank_q.
REQ-016 In DRAWING, when frame_done=1 and either vb_rise=0 or enable=0, the next state SHALL be PENDING.
REQ-017 In DRAWING, when frame_done=1, vb_rise=1 and enable=1 in the same cycle, the next state SHALL be SWAP.
REQ-018 In DRAWING, when vb_rise=1, frame_done=0 and enable=1, drop_count SHALL increment by 1, saturating at 2^CNT_W-1.
REQ-019 In PENDING, when vb_rise=1 and enable=1, the next state SHALL be SWAP; otherwise the FSM SHALL remain in PENDING.
REQ-020 frameswap SHALL be 1 exactly in the cycle the FSM is in SWAP, and SWAP SHALL always return to DRAWING after one cycle.
REQ-021 At the clock edge leaving SWAP, draw_sel SHALL toggle and swap_count SHALL increment by 1, wrapping.
REQ-022 Latency from the qualifying vb_rise cycle to the frameswap pulse SHALL be exactly 1 cycle.
REQ-023 draw_stall SHALL be 1 in PENDING and SWAP, and 0 in DRAWING.
REQ-024 A frame_done while in PENDING or SWAP SHALL set proto_err, SHALL be otherwise ignored, and SHALL NOT change state.
REQ-025 With enable=0, vb_rise SHALL neither trigger a swap nor increment drop_count.
REQ-026 vblank held high SHALL produce only one vb_rise, so at most one swap occurs per vblank.

Reset
REQ-027 While n_rst=0, all outputs and state SHALL take their reset values immediately, independent of clk.
REQ-028 Reset values: state=DRAWING, vblank_q=0, frameswap=0, draw_sel=0, disp_sel=1, draw_stall=0, swap_count=0, drop_count=0, proto_err=0.
REQ-029 A reset asserted during PENDING or SWAP SHALL discard the pending swap, with no frameswap pulse after release.
REQ-030 proto_err SHALL be cleared only by reset.

Structure
REQ-031 The state enum (DRAWING, PENDING, SWAP) and the CNT_W default SHALL reside in the shared package fb_pkg.
REQ-032 Vblank edge detection SHALL be a sub-module vblank_edge_det (inputs clk, n_rst, vblank; output vb_rise).
REQ-033 All other logic SHALL be in frame_swap_ctrl, with one registered state and no combinational output loops.

Verification
REQ-034 Normal swap: after reset, enable=1, pulse frame_done at cycle 5, vblank rises at cycle 20 -> frameswap=1 at cycle 21 only; draw_sel 0->1, swap_count=1, draw_stall 1 during cycles 6-21.
REQ-035 Simultaneous events: in DRAWING, frame_done and vb_rise occur in the same cycle -> frameswap on the next cycle, and drop_count is unchanged.
REQ-036 Dropped frames: three vblank rises with no frame_done -> drop_count=3, with no frameswap; 300 rises with CNT_W=8 -> drop_count=255.
REQ-037 Disable: enable=0 with frame_done then a vblank rise -> FSM stays in PENDING with no swap; raising enable before the next rise -> swap on that rise+1.
REQ-038 Protocol error: a second frame_done while in PENDING -> proto_err=1 and remains 1 until n_rst=0.
REQ-039 Reset mid-operation: assert n_rst in PENDING -> outputs take reset values asynchronously; after release a vblank rise produces no frameswap.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared types and defaults for the frame buffer swap controller.
package fb_pkg;

  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    DRAWING = 2'd0,
    PENDING = 2'd1,
    SWAP    = 2'd2
  } fb_state_e;

endpackage

// File: rtl/vblank_edge_det.sv
// Rising-edge detector for the display vertical-blank level.
module vblank_edge_det (
  input  logic clk,
  input  logic n_rst,
  input  logic vblank,
  output logic vb_rise
);

  logic vblank_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) vblank_q <= 1'b0;
    else        vblank_q <= vblank;
  end

  // A held-high vblank yields one rise, so at most one swap per blank.
  assign vb_rise = vblank & ~vblank_q;

endmodule

// File: rtl/frame_swap_ctrl.sv
// Double-buffer swap controller: swaps draw/display buffers on the first
// vblank rise after the renderer finishes a frame.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   DRAWING | renderer busy on back buffer; vblank rises here count drops
//   PENDING | frame complete, renderer stalled, waiting for vblank rise
//   SWAP    | one-cycle frameswap pulse; buffers flip on exit
module frame_swap_ctrl
  import fb_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             enable,
  input  logic             frame_done,
  input  logic             vblank,
  output logic             frameswap,
  output logic             draw_sel,
  output logic             disp_sel,
  output logic             draw_stall,
  output logic [CNT_W-1:0] swap_count,
  output logic [CNT_W-1:0] drop_count,
  output logic             proto_err
);

  fb_state_e        state_q, state_d;
  logic             vb_rise;
  logic             swap_ok;
  logic             draw_sel_q;
  logic             proto_err_q;
  logic [CNT_W-1:0] swap_count_q;
  logic [CNT_W-1:0] drop_count_q;

  vblank_edge_det u_vb_edge (
    .clk     (clk),
    .n_rst   (n_rst),
    .vblank  (vblank),
    .vb_rise (vb_rise)
  );

  assign swap_ok = vb_rise & enable;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= DRAWING;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DRAWING: if (frame_done) state_d = swap_ok ? SWAP : PENDING;
      PENDING: if (swap_ok)    state_d = SWAP;
      SWAP:                    state_d = DRAWING;
      default:                 state_d = DRAWING;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      draw_sel_q   <= 1'b0;
      swap_count_q <= '0;
      drop_count_q <= '0;
      proto_err_q  <= 1'b0;
    end else begin
      if (state_q == SWAP) begin
        draw_sel_q   <= ~draw_sel_q;
        swap_count_q <= swap_count_q + CNT_W'(1);
      end
      // A vblank passing while the renderer is still drawing repeats a frame.
      if (state_q == DRAWING && swap_ok && !frame_done && drop_count_q != '1)
        drop_count_q <= drop_count_q + CNT_W'(1);
      if (frame_done && state_q != DRAWING)
        proto_err_q <= 1'b1;
    end
  end

  assign frameswap  = (state_q == SWAP);
  assign draw_stall = (state_q != DRAWING);
  assign draw_sel   = draw_sel_q;
  assign disp_sel   = ~draw_sel_q;
  assign swap_count = swap_count_q;
  assign drop_count = drop_count_q;
  assign proto_err  = proto_err_q;

endmodule

// File: tb/tb_frame_swap_ctrl.sv
// Self-checking bench for frame_swap_ctrl: directed scenarios plus random
// traffic compared against a behavioural model of the swap rules.
module tb_frame_swap_ctrl;

  localparam int CNT_W = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             n_rst = 1'b0;
  logic             enable = 1'b0;
  logic             frame_done = 1'b0;
  logic             vblank = 1'b0;
  logic             frameswap, draw_sel, disp_sel, draw_stall, proto_err;
  logic [CNT_W-1:0] swap_count, drop_count;

  int n_checks = 0;
  int n_errors = 0;

  // model: a finished frame waits for a vblank; the swap is a one-cycle event
  bit m_vb_prev, m_have_frame, m_swapping, m_draw_sel, m_err;
  int m_swaps, m_drops;

  frame_swap_ctrl #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .enable     (enable),
    .frame_done (frame_done),
    .vblank     (vblank),
    .frameswap  (frameswap),
    .draw_sel   (draw_sel),
    .disp_sel   (disp_sel),
    .draw_stall (draw_stall),
    .swap_count (swap_count),
    .drop_count (drop_count),
    .proto_err  (proto_err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_vb_prev = 0; m_have_frame = 0; m_swapping = 0;
    m_draw_sel = 0; m_err = 0; m_swaps = 0; m_drops = 0;
  endtask

  task automatic model_step(input bit fd, input bit vb, input bit en);
    bit rise;
    rise = vb && !m_vb_prev;
    m_vb_prev = vb;
    if (m_swapping) begin
      m_swapping = 0;
      m_draw_sel = !m_draw_sel;
      m_swaps = (m_swaps + 1) % (CNT_MAX + 1);
      if (fd) m_err = 1;
    end else if (m_have_frame) begin
      if (fd) m_err = 1;
      if (rise && en) begin
        m_have_frame = 0;
        m_swapping = 1;
      end
    end else if (fd) begin
      if (rise && en) m_swapping = 1;
      else            m_have_frame = 1;
    end else if (rise && en && m_drops < CNT_MAX) begin
      m_drops++;
    end
  endtask

  task automatic compare_all();
    check_val("frameswap",  frameswap,  m_swapping);
    check_val("draw_stall", draw_stall, m_have_frame | m_swapping);
    check_val("draw_sel",   draw_sel,   m_draw_sel);
    check_val("disp_sel",   disp_sel,   !m_draw_sel);
    check_val("swap_count", swap_count, m_swaps);
    check_val("drop_count", drop_count, m_drops);
    check_val("proto_err",  proto_err,  m_err);
  endtask

  // one clock cycle: inputs applied at negedge, outputs compared at next negedge
  task automatic cyc(input bit fd, input bit vb, input bit en);
    frame_done = fd; vblank = vb; enable = en;
    @(posedge clk);
    model_step(fd, vb, en);
    @(negedge clk);
    compare_all();
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_frameswap"},  frameswap,  0);
    check_val({tag, "_draw_sel"},   draw_sel,   0);
    check_val({tag, "_disp_sel"},   disp_sel,   1);
    check_val({tag, "_draw_stall"}, draw_stall, 0);
    check_val({tag, "_swap_count"}, swap_count, 0);
    check_val({tag, "_drop_count"}, drop_count, 0);
    check_val({tag, "_proto_err"},  proto_err,  0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 n_rst = 1'b0;
    frame_done = 0; vblank = 0; enable = 0;
    #1 check_reset_vals("rst");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  initial begin
    model_reset();
    do_reset();

    // normal swap: frame_done in cycle 5, vblank rises in cycle 20
    for (int c = 1; c <= 4; c++) cyc(0, 0, 1);
    cyc(1, 0, 1);
    check_val("n34_stall_c6", draw_stall, 1);
    for (int c = 6; c <= 19; c++) cyc(0, 0, 1);
    cyc(0, 1, 1);
    check_val("n34_swap_c21", frameswap, 1);
    check_val("n34_stall_c21", draw_stall, 1);
    cyc(0, 1, 1);
    check_val("n34_swap_off", frameswap, 0);
    check_val("n34_draw_sel", draw_sel, 1);
    check_val("n34_swap_cnt", swap_count, 1);
    check_val("n34_stall_off", draw_stall, 0);
    cyc(0, 0, 1);

    // frame_done coincident with vblank rise: swap next cycle, no drop
    cyc(1, 1, 1);
    check_val("sim_swap", frameswap, 1);
    check_val("sim_drop", drop_count, 0);
    cyc(0, 0, 1);
    check_val("sim_sel", draw_sel, 0);

    // three vblank rises without a frame
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 1);
      cyc(0, 0, 1);
    end
    check_val("drop3", drop_count, 3);
    check_val("drop3_swaps", swap_count, 2);

    // enable low: frame parks in PENDING through a rise, swaps on next enabled rise
    cyc(1, 0, 0);
    cyc(0, 1, 0);
    check_val("dis_noswap", frameswap, 0);
    check_val("dis_stall", draw_stall, 1);
    cyc(0, 0, 1);
    cyc(0, 1, 1);
    check_val("dis_swap", frameswap, 1);
    cyc(0, 0, 1);

    // held vblank with enable low never counts drops
    cyc(0, 1, 0);
    cyc(0, 1, 1);
    check_val("held_nodrop", drop_count, 3);
    cyc(0, 0, 1);

    // second frame_done while pending is sticky error
    cyc(1, 0, 1);
    cyc(1, 0, 1);
    check_val("perr_set", proto_err, 1);
    cyc(0, 1, 1);
    cyc(0, 0, 1);
    check_val("perr_sticky", proto_err, 1);

    // reset while pending: immediate reset values, no swap afterwards
    cyc(1, 0, 1);
    check_val("mid_pending", draw_stall, 1);
    do_reset();
    cyc(0, 1, 1);
    check_val("mid_noswap", frameswap, 0);
    check_val("mid_nostall", draw_stall, 0);
    cyc(0, 0, 1);

    // drop counter saturation
    for (int i = 0; i < 300; i++) begin
      cyc(0, 1, 1);
      cyc(0, 0, 1);
    end
    check_val("drop_sat", drop_count, CNT_MAX);
    check_val("drop_sat_swaps", swap_count, 0);

    // randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bit fd, vb, en;
      fd = ($urandom_range(0, 5) == 0);
      vb = ($urandom_range(0, 7) == 0) ? !vblank : vblank;
      en = ($urandom_range(0, 7) != 0);
      if (i % 1000 == 999) begin
        do_reset();
      end else begin
        cyc(fd, vb, en);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
